// File: rtl/fsab_pkg.sv
// Shared FSAB bus widths, credit constants, mode encoding and request-side types.
package fsab_pkg;

   localparam int FSAB_DID_W           = 4;
   localparam int FSAB_ADDR_W          = 31;
   localparam int FSAB_LEN_W           = 4;
   localparam int FSAB_LEN_MAX         = 8;
   localparam int FSAB_DATA_W          = 64;
   localparam int FSAB_MASK_W          = 8;
   localparam int FSAB_INITIAL_CREDITS = 4;
   localparam int FSAB_CREDITS_W       = 3;

   typedef enum logic {
      FSAB_READ  = 1'b0,
      FSAB_WRITE = 1'b1
   } fsab_mode_t;

   typedef enum logic {
      ST_IDLE,
      ST_WBURST
   } req_state_t;

   typedef struct packed {
      fsab_mode_t              mode;
      logic [FSAB_DID_W-1:0]   did;
      logic [FSAB_DID_W-1:0]   subdid;
      logic [FSAB_ADDR_W-1:0]  addr;
      logic [FSAB_LEN_W-1:0]   len;
   } fsab_hdr_t;

   typedef struct packed {
      logic [FSAB_DATA_W-1:0]  data;
      logic [FSAB_MASK_W-1:0]  mask;
   } fsab_beat_t;

   function automatic logic fsab_len_ok(input logic [FSAB_LEN_W-1:0] len);
      return (len != '0) && (len <= FSAB_LEN_W'(FSAB_LEN_MAX));
   endfunction

endpackage

// File: rtl/fsab_rdq.sv
// Synchronous FIFO of outstanding read lengths; head visible combinationally, 1-cycle push latency.
// Push is dropped when full and pop when empty; storage is reset so the head never reads X.
module fsab_rdq
   import fsab_pkg::*;
#(
   parameter int WIDTH = FSAB_LEN_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             Nrst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fsab_requester.sv
// FSAB initiator: client beat accepted in N appears on fsabo in N+1; fsabi beat in N gives rd_* in N+1.
// req_ready drops in IDLE when credits are exhausted, the read queue is full (reads only) or req_len is illegal.
module fsab_requester
   import fsab_pkg::*;
#(
   parameter int DID       = 0,
   parameter int RDQ_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    Nrst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [FSAB_DID_W-1:0]   req_subdid,
   input  logic [FSAB_ADDR_W-1:0]  req_addr,
   input  logic [FSAB_LEN_W-1:0]   req_len,
   input  logic [FSAB_DATA_W-1:0]  req_data,
   input  logic [FSAB_MASK_W-1:0]  req_mask,
   output logic                    fsabo_valid,
   output fsab_mode_t              fsabo_mode,
   output logic [FSAB_DID_W-1:0]   fsabo_did,
   output logic [FSAB_DID_W-1:0]   fsabo_subdid,
   output logic [FSAB_ADDR_W-1:0]  fsabo_addr,
   output logic [FSAB_LEN_W-1:0]   fsabo_len,
   output logic [FSAB_DATA_W-1:0]  fsabo_data,
   output logic [FSAB_MASK_W-1:0]  fsabo_mask,
   input  logic                    fsabo_credit,
   input  logic                    fsabi_valid,
   input  logic [FSAB_DID_W-1:0]   fsabi_did,
   input  logic [FSAB_DID_W-1:0]   fsabi_subdid,
   input  logic [FSAB_DATA_W-1:0]  fsabi_data,
   output logic                    rd_valid,
   output logic [FSAB_DATA_W-1:0]  rd_data,
   output logic [FSAB_DID_W-1:0]   rd_subdid,
   output logic                    rd_last
);

   localparam logic [FSAB_DID_W-1:0]     DID_L     = FSAB_DID_W'(DID);
   localparam logic [FSAB_LEN_W-1:0]     LEN_ONE   = FSAB_LEN_W'(1);
   localparam logic [FSAB_CREDITS_W-1:0] CRED_INIT = FSAB_CREDITS_W'(FSAB_INITIAL_CREDITS);
   localparam logic [FSAB_CREDITS_W-1:0] CRED_ONE  = FSAB_CREDITS_W'(1);

   req_state_t                state;
   req_state_t                state_nxt;
   logic [FSAB_LEN_W-1:0]     beats_rem;
   logic [FSAB_LEN_W-1:0]     beats_rem_nxt;
   logic [FSAB_CREDITS_W-1:0] credits;
   logic                      hdr_issue;
   logic                      beat_accept;
   logic                      rdq_push;
   logic                      rdq_full;
   logic                      rdq_empty;
   logic [FSAB_LEN_W-1:0]     rdq_head_len;
   logic [FSAB_LEN_W-1:0]     rbeat;
   logic                      fsabi_match;
   logic                      rd_take;
   logic                      rd_last_c;
   fsab_hdr_t                 hdr_q;
   fsab_beat_t                beat_q;

   assign fsabo_mode   = hdr_q.mode;
   assign fsabo_did    = hdr_q.did;
   assign fsabo_subdid = hdr_q.subdid;
   assign fsabo_addr   = hdr_q.addr;
   assign fsabo_len    = hdr_q.len;
   assign fsabo_data   = beat_q.data;
   assign fsabo_mask   = beat_q.mask;

   assign beat_accept  = req_valid && req_ready;

   always_comb begin
      state_nxt     = state;
      beats_rem_nxt = beats_rem;
      req_ready     = 1'b0;
      hdr_issue     = 1'b0;
      rdq_push      = 1'b0;
      case (state)
         ST_IDLE: begin
            // Ready never looks at fsabo_credit, so a returned credit is usable one cycle later
            req_ready = (credits != '0) && (req_write || !rdq_full) && fsab_len_ok(req_len);
            if (req_valid && req_ready) begin
               hdr_issue = 1'b1;
               if (!req_write) begin
                  rdq_push = 1'b1;
               end else if (req_len != LEN_ONE) begin
                  beats_rem_nxt = req_len - LEN_ONE;
                  state_nxt     = ST_WBURST;
               end
            end
         end
         ST_WBURST: begin
            req_ready = 1'b1;
            if (req_valid) begin
               beats_rem_nxt = beats_rem - LEN_ONE;
               if (beats_rem == LEN_ONE) state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         state     <= ST_IDLE;
         beats_rem <= '0;
      end else begin
         state     <= state_nxt;
         beats_rem <= beats_rem_nxt;
      end
   end

   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         fsabo_valid <= 1'b0;
         hdr_q       <= '0;
         beat_q      <= '0;
      end else begin
         fsabo_valid <= beat_accept;
         if (hdr_issue) begin
            hdr_q <= '{mode:   (req_write ? FSAB_WRITE : FSAB_READ),
                       did:    DID_L,
                       subdid: req_subdid,
                       addr:   req_addr,
                       len:    req_len};
         end
         if (beat_accept) beat_q <= '{data: req_data, mask: req_mask};
      end
   end

   // Only headers spend credits; a return beyond the initial pool saturates
   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         credits <= CRED_INIT;
      end else begin
         case ({hdr_issue, fsabo_credit})
            2'b10:   credits <= credits - CRED_ONE;
            2'b01:   if (credits != CRED_INIT) credits <= credits + CRED_ONE;
            default: credits <= credits;
         endcase
      end
   end

   assign fsabi_match = fsabi_valid && (fsabi_did == DID_L);
   assign rd_take     = fsabi_match && !rdq_empty;
   assign rd_last_c   = rd_take && ((rbeat + LEN_ONE) == rdq_head_len);

   fsab_rdq #(
      .WIDTH (FSAB_LEN_W),
      .DEPTH (RDQ_DEPTH)
   ) u_rdq (
      .clk       (clk),
      .Nrst      (Nrst),
      .push      (rdq_push),
      .push_data (req_len),
      .pop       (rd_last_c),
      .head_data (rdq_head_len),
      .full      (rdq_full),
      .empty     (rdq_empty)
   );

   always_ff @(posedge clk or negedge Nrst) begin
      if (!Nrst) begin
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
         rd_subdid <= '0;
         rbeat     <= '0;
      end else begin
         rd_valid <= rd_take;
         rd_last  <= rd_last_c;
         if (rd_take) begin
            rd_data   <= fsabi_data;
            rd_subdid <= fsabi_subdid;
         end
         if (rd_last_c)    rbeat <= '0;
         else if (rd_take) rbeat <= rbeat + LEN_ONE;
      end
   end

   a_credit_overflow: assert property (@(posedge clk) disable iff (!Nrst)
      !(fsabo_credit && !hdr_issue && credits == CRED_INIT));
   a_orphan_read_beat: assert property (@(posedge clk) disable iff (!Nrst)
      !(fsabi_match && rdq_empty));
   a_illegal_len: assert property (@(posedge clk) disable iff (!Nrst)
      !(state == ST_IDLE && req_valid && !fsab_len_ok(req_len)));

endmodule

// File: doc/fsab_requester.md
# fsab_requester

Generic FSAB initiator that turns a simple local request/data port into FSAB request traffic on the fsabo bus and collects read data returned on the fsabi bus. It sits between a client (cache fill engine, DMA, framebuffer fetch) and the FSAB arbiter/memory. It enforces the credit-based flow control the memory side advertises on fsabo_credit, and tracks outstanding reads so that each returned burst is delimited for the client.

## Interface
Parameters:
- DID, default 0: device ID driven on fsabo_did; only fsabi beats with fsabi_did == DID are accepted.
- RDQ_DEPTH, default 4: maximum outstanding read requests.

Ports:
- clk  in  1  clock
- Nrst  in  1  reset, asynchronous, active-low
- req_valid  in  1  client presents a request beat
- req_ready  out  1  beat accepted this cycle
- req_write  in  1  1 = write, 0 = read; sampled on header beat
- req_subdid  in  FSAB_DID_W  sub-ID; sampled on header beat
- req_addr  in  FSAB_ADDR_W  byte address; sampled on header beat
- req_len  in  FSAB_LEN_W  burst length in beats, 1..FSAB_LEN_MAX
- req_data  in  FSAB_DATA_W  write data for this beat
- req_mask  in  FSAB_MASK_W  byte enables for this beat
- fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask  out  per package  FSAB request bus, all registered
- fsabo_credit  in  1  one pulse per request header consumed by the memory side
- fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data  in  per package  FSAB response bus
- rd_valid  out  1  read data beat for this client
- rd_data  out  FSAB_DATA_W  read data
- rd_subdid  out  FSAB_DID_W  sub-ID from fsabi
- rd_last  out  1  final beat of the oldest outstanding read

## Operation
- Credit counter `credits`, width FSAB_CREDITS_W. It resets to FSAB_INITIAL_CREDITS (4).
  - Header issue decrements it.
  - fsabo_credit increments it.
  - Both in the same cycle: unchanged.
  - Increment at FSAB_INITIAL_CREDITS is an assertion error and saturates.
- FSM states:
  - IDLE: req_ready = req_valid-independent (credits != 0) && (req_write || !rdq_full).
    - On acceptance with req_write = 0: send a read header with fsabo_mode = FSAB_READ, push req_len into the read queue, stay in IDLE.
    - On acceptance with req_write = 1: send a header with fsabo_mode = FSAB_WRITE, carrying req_data/req_mask as beat 0. If req_len == 1, stay in IDLE; otherwise load beats_rem = req_len-1 and go to WBURST.
  - WBURST: req_ready = 1. Each accepted beat drives fsabo_valid with data/mask. Header fields are held at their header values, and beats_rem decrements. At beats_rem == 1 on acceptance, go to IDLE. Credits are not consumed by data beats.
- When no beat is accepted, fsabo_valid = 0 next cycle and the other fsabo fields hold.
- A write does not block on read-queue fullness. Writes return no fsabi traffic.
- Read return path:
  - Sub-module fsab_rdq (FIFO of lengths) is popped when rd_last is asserted.
  - A counter rbeat counts matching fsabi beats.
  - rd_last = (rbeat+1 == rdq_head_len). rbeat clears on rd_last.
  - A matching fsabi beat with rdq empty is an assertion error; the beat is dropped and rd_valid stays 0.
- req_len == 0 or > FSAB_LEN_MAX on a header beat is an assertion error. The request is not issued and req_ready = 0.

## Timing
- Reset values: fsabo_valid 0, all fsabo fields 0, rd_valid 0, rd_last 0, credits = 4, FSM IDLE, rdq empty, rbeat 0.
- Reset mid-burst aborts the burst with no completion; the client must restart.
- req_ready is combinational from state, credits and rdq_full. It does not depend on fsabo_credit in the same cycle: a credit returned in cycle N is usable in N+1.
- Accepted beat in cycle N → fsabo_valid in cycle N+1.
- A write burst of length L occupies L consecutive fsabo cycles only if the client holds req_valid. Gaps are legal and produce fsabo_valid = 0 cycles mid-burst.
- fsabi beat in cycle N → rd_valid/rd_data/rd_last in cycle N+1 (registered).
- A read queue push and pop in the same cycle are both honoured. Read header and last read beat may coincide.

## Structure
- The shared package fsab_pkg holds:
  - FSAB_DID_W 4, FSAB_ADDR_W 31, FSAB_LEN_W 4, FSAB_LEN_MAX 8, FSAB_DATA_W 64, FSAB_MASK_W 8.
  - FSAB_INITIAL_CREDITS 4, FSAB_CREDITS_W 3.
  - Mode enum FSAB_READ = 0, FSAB_WRITE = 1.
- One sub-module, fsab_rdq: parameterised synchronous FIFO (width FSAB_LEN_W, depth RDQ_DEPTH) with full/empty, synthesizable, no x-reads.

## Test plan
- Single read: read addr 0x100, len 4, DID 2. Expect one fsabo header with mode READ and len 4. Then 4 fsabi beats with did 2 → 4 rd_valid, rd_last on beat 4 only.
- Credit exhaustion: 5 back-to-back reads, no fsabo_credit. Expect 4 headers, req_ready 0 on the 5th. Pulse fsabo_credit once → 5th header issues 2 cycles later.
- Write burst: write len 8 with data 0..7 and mask 0xFF. Expect 8 consecutive fsabo_valid cycles, header fields constant, credits 4→3. A 1-cycle req_valid gap produces a 1-cycle fsabo_valid hole.
- DID filter and queue: RDQ_DEPTH reads of len 1, 2, 3, 4. Interleaved fsabi beats with a foreign DID are ignored. rd_last fires after beats 1, 3, 6, 10. Read blocked while rdq full even with credits available.
- Simultaneous credit return and header issue: credits stay constant.
- Reset mid-WBURST → all outputs zero, credits 4, next request issues cleanly.
